// File: rtl/logic_op_issue_queue.sv
// Purpose : command FIFO feeding the 4-bit logic unit (AND/OR/XOR/NOT-a), with a registered result port.
// Latency : a command pushed at edge N into an empty queue with an idle result register is valid after edge N+1.
// Backpr. : cmd_ready drops at DEPTH entries; a stalled result (res_valid && !res_ready) holds and blocks pops.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake; cmd_a, cmd_b, cmd_sel carry the command
//   alu_a, alu_b, alu_sel         head entry to the logic unit (zero when the queue is empty)
//   alu_y                         combinational return from the logic unit
//   res_valid/res_ready           result handshake; res_y, res_sel carry the result and its op
//   count                         current FIFO occupancy
module logic_op_issue_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [W-1:0]             cmd_a,
  input  logic [W-1:0]             cmd_b,
  input  logic [1:0]               cmd_sel,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  output logic [1:0]               alu_sel,
  input  logic [W-1:0]             alu_y,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [W-1:0]             res_y,
  output logic [1:0]               res_sel,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [1:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            rdy_en;
  logic            not_empty;
  logic            push;
  logic            pop;

  assign not_empty = (cnt != '0);

  // rdy_en keeps cmd_ready low while in reset and for the release cycle;
  // it rises on the first clock edge after rst_n deasserts.
  assign cmd_ready = rdy_en && (cnt < CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  // The result register is free when empty or being consumed this cycle.
  assign pop       = not_empty && (!res_valid || res_ready);

  assign head    = mem[rd_ptr];
  // Storage is not reset, so the unit inputs are gated to avoid exposing X.
  assign alu_a   = not_empty ? head.a   : '0;
  assign alu_b   = not_empty ? head.b   : '0;
  assign alu_sel = not_empty ? head.sel : '0;
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{sel: cmd_sel, a: cmd_a, b: cmd_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      rdy_en <= 1'b1;
      // Pointers are power-of-two sized, so the increment wraps on its own.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_y     <= '0;
      res_sel   <= '0;
    end else if (pop) begin
      res_valid <= 1'b1;
      res_y     <= alu_y;
      res_sel   <= head.sel;
    end else if (res_valid && res_ready) begin
      // Consumed with nothing behind it: drop valid, keep the last data.
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_op_issue_queue.sv
module tb_logic_op_issue_queue;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_sel;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_sel;
  logic [3:0] alu_y;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_y;
  logic [1:0] res_sel;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  logic [3:0] ops_y [4] = '{4'h8, 4'hE, 4'h6, 4'h3};

  logic_op_issue_queue #(.DEPTH(4), .W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_y     (alu_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
    .res_sel   (res_sel),
    .count     (count)
  );

  // Behavioural stand-in for the combinational logic unit.
  always_comb begin
    alu_y = 4'h0;
    case (alu_sel)
      2'b00: alu_y = alu_a & alu_b;
      2'b01: alu_y = alu_a | alu_b;
      2'b10: alu_y = alu_a ^ alu_b;
      2'b11: alu_y = ~alu_a;
      default: alu_y = 4'h0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    cmd_valid = v;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = s;
  endtask

  initial begin
    rst_n     = 1'b0;
    res_ready = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 2'b00);

    // Reset state
    step;
    chk("rst_res_valid", 16'(res_valid), 16'h0);
    chk("rst_count",     16'(count),     16'h0);
    chk("rst_cmd_ready", 16'(cmd_ready), 16'h0);
    chk("rst_res_y",     16'(res_y),     16'h0);
    chk("rst_res_sel",   16'(res_sel),   16'h0);
    chk("rst_alu",       16'({alu_a, alu_b, alu_sel}), 16'h0);
    #3 rst_n = 1'b1;
    #1 chk("rel_cmd_ready_low", 16'(cmd_ready), 16'h0);
    step;
    chk("rel_cmd_ready_high", 16'(cmd_ready), 16'h1);

    // Single op: C AND A = 8
    res_ready = 1'b1;
    drive(1'b1, 4'hC, 4'hA, 2'b00);
    step;
    drive(1'b0, 4'h0, 4'h0, 2'b00);
    chk("single_alu_a",   16'(alu_a),   16'hC);
    chk("single_alu_b",   16'(alu_b),   16'hA);
    chk("single_alu_sel", 16'(alu_sel), 16'h0);
    chk("single_count1",  16'(count),   16'h1);
    chk("single_nores",   16'(res_valid), 16'h0);
    step;
    chk("single_res_valid", 16'(res_valid), 16'h1);
    chk("single_res_y",     16'(res_y),     16'h8);
    chk("single_res_sel",   16'(res_sel),   16'h0);
    chk("single_count0",    16'(count),     16'h0);
    chk("single_gated",     16'(alu_a),     16'h0);
    step;
    chk("single_drop_valid", 16'(res_valid), 16'h0);
    chk("single_drop_count", 16'(count),     16'h0);

    // All four ops back-to-back on a=C, b=A
    drive(1'b1, 4'hC, 4'hA, 2'b00);
    step;
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) cmd_sel = 2'(i);
      else       cmd_valid = 1'b0;
      step;
      chk("ops_valid", 16'(res_valid), 16'h1);
      chk("ops_y",     16'(res_y),     16'(ops_y[i-1]));
      chk("ops_sel",   16'(res_sel),   16'(i-1));
    end
    step;
    chk("ops_idle", 16'(res_valid), 16'h0);

    // Backpressure and full queue: results 1..5, ops alternate OR/XOR with b=0
    res_ready = 1'b0;
    drive(1'b1, 4'h1, 4'h0, 2'b01); step;
    drive(1'b1, 4'h2, 4'h0, 2'b10); step;
    chk("bp_first_valid", 16'(res_valid), 16'h1);
    chk("bp_first_y",     16'(res_y),     16'h1);
    drive(1'b1, 4'h3, 4'h0, 2'b01); step;
    drive(1'b1, 4'h4, 4'h0, 2'b10); step;
    drive(1'b1, 4'h5, 4'h0, 2'b01); step;
    chk("bp_count_full", 16'(count),     16'h4);
    chk("bp_ready_low",  16'(cmd_ready), 16'h0);
    chk("bp_hold_y",     16'(res_y),     16'h1);
    // A sixth offer while full must be refused
    drive(1'b1, 4'hE, 4'hE, 2'b00); step;
    chk("bp_no_push",    16'(count),     16'h4);
    chk("bp_hold_y2",    16'(res_y),     16'h1);
    chk("bp_hold_sel",   16'(res_sel),   16'h1);
    chk("bp_hold_valid", 16'(res_valid), 16'h1);
    drive(1'b0, 4'h0, 4'h0, 2'b00);
    res_ready = 1'b1;
    step;
    chk("bp_ready_back", 16'(cmd_ready), 16'h1);
    chk("bp_drain_y2",   16'(res_y),     16'h2);
    chk("bp_drain_s2",   16'(res_sel),   16'h2);
    chk("bp_count3",     16'(count),     16'h3);
    step; chk("bp_drain_y3", 16'(res_y), 16'h3);
    step; chk("bp_drain_y4", 16'(res_y), 16'h4);
    step;
    chk("bp_drain_y5",   16'(res_y),     16'h5);
    chk("bp_drain_s5",   16'(res_sel),   16'h1);
    chk("bp_count0",     16'(count),     16'h0);
    step;
    chk("bp_empty_valid", 16'(res_valid), 16'h0);

    // Simultaneous push/pop at count=2 with pointer wrap; command k carries a=k
    res_ready = 1'b0;
    drive(1'b1, 4'h0, 4'h0, 2'b10); step;
    drive(1'b1, 4'h1, 4'h0, 2'b01); step;
    drive(1'b1, 4'h2, 4'h0, 2'b10); step;
    chk("pp_count2", 16'(count), 16'h2);
    chk("pp_res0",   16'(res_y), 16'h0);
    res_ready = 1'b1;
    for (int j = 3; j <= 12; j++) begin
      drive(1'b1, 4'(j), 4'h0, (j % 2 == 1) ? 2'b01 : 2'b10);
      step;
      chk("pp_count",  16'(count),     16'h2);
      chk("pp_valid",  16'(res_valid), 16'h1);
      chk("pp_y",      16'(res_y),     16'(j - 2));
      chk("pp_sel",    16'(res_sel),   ((j - 2) % 2 == 1) ? 16'h1 : 16'h2);
    end
    drive(1'b0, 4'h0, 4'h0, 2'b00);
    step;
    chk("pp_tail_y11", 16'(res_y), 16'hB);
    chk("pp_tail_c1",  16'(count), 16'h1);
    step;
    chk("pp_tail_y12", 16'(res_y), 16'hC);
    chk("pp_tail_c0",  16'(count), 16'h0);
    step;
    chk("pp_tail_idle", 16'(res_valid), 16'h0);

    // Asynchronous reset with count=3 and a held result
    res_ready = 1'b0;
    drive(1'b1, 4'h1, 4'h1, 2'b00); step;
    drive(1'b1, 4'h2, 4'h2, 2'b00); step;
    drive(1'b1, 4'h3, 4'h3, 2'b00); step;
    drive(1'b1, 4'h4, 4'h4, 2'b00); step;
    drive(1'b0, 4'h0, 4'h0, 2'b00);
    chk("ar_pre_count", 16'(count),     16'h3);
    chk("ar_pre_valid", 16'(res_valid), 16'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid",     16'(res_valid), 16'h0);
    chk("ar_count",     16'(count),     16'h0);
    chk("ar_cmd_ready", 16'(cmd_ready), 16'h0);
    chk("ar_alu",       16'({alu_a, alu_b, alu_sel}), 16'h0);
    #7 rst_n = 1'b1;
    res_ready = 1'b1;
    step;
    chk("ar_ready_back", 16'(cmd_ready), 16'h1);
    for (int k = 0; k < 3; k++) begin
      step;
      chk("ar_no_stale", 16'(res_valid), 16'h0);
    end
    drive(1'b1, 4'hF, 4'h0, 2'b01);
    step;
    drive(1'b0, 4'h0, 4'h0, 2'b00);
    step;
    chk("ar_new_valid", 16'(res_valid), 16'h1);
    chk("ar_new_y",     16'(res_y),     16'hF);
    chk("ar_new_sel",   16'(res_sel),   16'h1);
    step;

    // Idle: unit inputs gated to zero and no results
    for (int k = 0; k < 20; k++) begin
      step;
      chk("idle_gate", 16'({alu_a, alu_b, alu_sel, res_valid}), 16'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
